multicycle_cu: RTL

MULTICYCLE_CU -- requirements
Module: multicycle_cu

---
 rtl/multicycle_cu.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// Multicycle control unit: IF/ID/EX/MEM/WB sequencer with memory timeout.
// Outputs are decoded from the current state and the opcode; zero is used in EX.
module multicycle_cu #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zero,
   input  logic       imReady,
   input  logic       dmReady,
   output logic       imRead,
   output logic       dmRead,
   output logic       dmWrite,
   output logic       irWrite,
   output logic       pcWrite,
   output logic       abWrite,
   output logic       aluOutWrite,
   output logic [1:0] pcSrc,
   output logic       imSel,
   output logic       selFunc,
   output logic       selDM,
   output logic       regSel,
   output logic       regWrite,
   output logic [7:0] funcCtrl,
   output logic [2:0] state,
   output logic       retire,
   output logic       memErr
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EX   = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b111
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_JUMP  = 4'b0010;
   localparam logic [3:0] OP_BRZ   = 4'b0100;
   localparam logic [3:0] OP_TYPEC = 4'b1000;
   localparam logic [3:0] OP_ADDI  = 4'b1100;
   localparam logic [3:0] OP_SUBI  = 4'b1101;
   localparam logic [3:0] OP_ANDI  = 4'b1110;
   localparam logic [3:0] OP_ORI   = 4'b1111;

   localparam logic [7:0] F_ADD = 8'b0000_0010;
   localparam logic [7:0] F_SUB = 8'b0000_0100;
   localparam logic [7:0] F_AND = 8'b0000_1000;
   localparam logic [7:0] F_OR  = 8'b0001_0000;
   localparam logic [7:0] F_NOP = 8'b0100_0000;

   state_t     r_state;
   state_t     w_nxt;
   logic [3:0] r_wait;
   logic [3:0] w_wait_nxt;
   logic       r_memErr;
   logic       w_hold;
   logic       w_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IF;
         r_wait   <= 4'd0;
         r_memErr <= 1'b0;
      end else begin
         r_state  <= w_nxt;
         r_wait   <= w_wait_nxt;
         if (w_timeout) r_memErr <= 1'b1;
      end
   end

   always_comb begin
      imRead      = 1'b0;
      dmRead      = 1'b0;
      dmWrite     = 1'b0;
      irWrite     = 1'b0;
      pcWrite     = 1'b0;
      abWrite     = 1'b0;
      aluOutWrite = 1'b0;
      pcSrc       = 2'b00;
      imSel       = 1'b0;
      selFunc     = 1'b0;
      selDM       = 1'b0;
      regSel      = 1'b0;
      regWrite    = 1'b0;
      funcCtrl    = F_NOP;
      retire      = 1'b0;
      state       = r_state;
      memErr      = r_memErr;
      w_nxt       = r_state;
      w_hold      = 1'b0;
      w_timeout   = 1'b0;
      w_wait_nxt  = 4'd0;

      case (r_state)
         S_IF: begin
            imRead = 1'b1;
            if (imReady) begin
               irWrite = 1'b1;
               pcWrite = 1'b1;
               w_nxt   = S_ID;
            end else begin
               w_hold = 1'b1;
            end
         end
         S_ID: begin
            abWrite = 1'b1;
            if (opcode == OP_JUMP) begin
               pcWrite = 1'b1;
               pcSrc   = 2'b10;
               retire  = 1'b1;
               w_nxt   = S_IF;
            end else begin
               w_nxt = S_EX;
            end
         end
         S_EX: begin
            case (opcode)
               OP_LOAD, OP_STORE: begin
                  imSel       = 1'b1;
                  funcCtrl    = F_ADD;
                  aluOutWrite = 1'b1;
                  w_nxt       = S_MEM;
               end
               OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
                  imSel       = 1'b1;
                  aluOutWrite = 1'b1;
                  w_nxt       = S_WB;
                  case (opcode[1:0])
                     2'b00:   funcCtrl = F_ADD;
                     2'b01:   funcCtrl = F_SUB;
                     2'b10:   funcCtrl = F_AND;
                     default: funcCtrl = F_OR;
                  endcase
               end
               OP_TYPEC: begin
                  selFunc     = 1'b1;
                  aluOutWrite = 1'b1;
                  w_nxt       = S_WB;
               end
               OP_BRZ: begin
                  funcCtrl = F_SUB;
                  if (zero) begin
                     pcWrite = 1'b1;
                     pcSrc   = 2'b01;
                  end
                  retire = 1'b1;
                  w_nxt  = S_IF;
               end
               default: begin
                  retire = 1'b1;
                  w_nxt  = S_IF;
               end
            endcase
         end
         S_MEM: begin
            // Only LOAD/STORE reach MEM; anything but STORE reads.
            if (opcode == OP_STORE) dmWrite = 1'b1;
            else                    dmRead  = 1'b1;
            if (dmReady) begin
               if (opcode == OP_STORE) begin
                  retire = 1'b1;
                  w_nxt  = S_IF;
               end else begin
                  w_nxt = S_WB;
               end
            end else begin
               w_hold = 1'b1;
            end
         end
         S_WB: begin
            regWrite = 1'b1;
            selDM    = (opcode == OP_LOAD);
            regSel   = (opcode == OP_TYPEC);
            retire   = 1'b1;
            w_nxt    = S_IF;
         end
         S_HALT: w_nxt = S_HALT;
         default: w_nxt = S_IF;
      endcase

      // A ready in the same cycle never counts as a wait.
      if (w_hold) begin
         w_wait_nxt = r_wait + 4'd1;
         if (r_wait == 4'(TIMEOUT - 1)) begin
            w_timeout = 1'b1;
            w_nxt     = S_HALT;
         end
      end

      if (rst) begin
         imRead      = 1'b0;
         dmRead      = 1'b0;
         dmWrite     = 1'b0;
         irWrite     = 1'b0;
         pcWrite     = 1'b0;
         abWrite     = 1'b0;
         aluOutWrite = 1'b0;
         pcSrc       = 2'b00;
         imSel       = 1'b0;
         selFunc     = 1'b0;
         selDM       = 1'b0;
         regSel      = 1'b0;
         regWrite    = 1'b0;
         funcCtrl    = F_NOP;
         retire      = 1'b0;
         state       = 3'b000;
         memErr      = 1'b0;
      end
   end

endmodule
